// File: rtl/div_share_sched.sv
// div_share_sched: round-robin scheduler sharing one iterative divider among NREQ requesters,
// with local divide-by-zero answers and a watchdog on the divider's done pulse.
module div_share_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DW      = 13,
    parameter int QW      = 12,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_dividend,
    input  logic [NREQ*DW-1:0]   req_divisor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [QW-1:0]        rsp_quotient,
    output logic                 rsp_dz,
    output logic                 rsp_to,
    output logic                 div_start,
    output logic [DW-1:0]        div_dividend,
    output logic [DW-1:0]        div_divisor,
    input  logic [QW-1:0]        div_quotient,
    input  logic                 div_done,
    output logic                 busy,
    output logic                 stray_done
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win, cand;
    logic [DW-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, g_dvd, g_dvs;
    logic [QW-1:0]  quo_q, quo_d;
    logic           dz_q, dz_d, to_q, to_d, stray_q, stray_d, found, grant;
    logic [TW-1:0]  tmr_q, tmr_d;

    // first valid requester searching from ptr upward, wrapping mod NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign grant     = (state_q == IDLE) && found;
    assign req_ready = grant ? NREQ'(1) << win : '0;
    assign g_dvd     = req_dividend[win*DW +: DW];
    assign g_dvs     = req_divisor[win*DW +: DW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        to_d    = to_q;
        tmr_d   = tmr_q;
        stray_d = stray_q | (div_done && state_q != WAIT);
        if (grant) begin
            id_d    = win;
            ptr_d   = IDW'((int'(win) + 1) % NREQ);
            dvd_d   = g_dvd;
            dvs_d   = g_dvs;
            dz_d    = g_dvs == '0;
            to_d    = 1'b0;
            quo_d   = g_dvs == '0 ? '1 : quo_q;
            state_d = g_dvs == '0 ? RESP : ISSUE;
        end else if (state_q == ISSUE) begin
            tmr_d   = '0;
            state_d = WAIT;
        end else if (state_q == WAIT) begin
            tmr_d = tmr_q + 1'b1;
            if (div_done) begin
                quo_d   = div_quotient;
                dz_d    = 1'b0;
                to_d    = 1'b0;
                state_d = RESP;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                quo_d   = '0;
                to_d    = 1'b1;
                state_d = RESP;
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            tmr_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            tmr_q   <= tmr_d;
            stray_q <= stray_d;
        end
    end

    assign rsp_valid    = state_q == RESP;
    assign rsp_id       = id_q;
    assign rsp_quotient = quo_q;
    assign rsp_dz       = dz_q;
    assign rsp_to       = to_q;
    assign div_start    = state_q == ISSUE;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign busy         = state_q != IDLE;
    assign stray_done   = stray_q;
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Scheduler that shares the single iterative resource divider (start/done protocol) among NREQ requesters.
- Round-robin arbitration; one outstanding divide at a time.
- Divide-by-zero is answered locally without starting the divider.
- A watchdog timer covers a divider that never returns `done`.
- Sits between the pipeline stages that need a quotient and the divider instance.

Parameters:
- NREQ, 4, number of requesters
- IDW, 2, requester id width (clog2 NREQ)
- DW, 13, dividend/divisor width
- QW, 12, quotient width (Q1.12 fraction, as produced by the divider)
- TIMEOUT, 32, max cycles in WAIT before forced error response

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_dividend  in  NREQ*DW  flattened dividends, requester i at [i*DW +: DW]
- req_divisor  in  NREQ*DW  flattened divisors, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that owns the response
- rsp_quotient  out  QW  result
- rsp_dz  out  1  divisor was zero
- rsp_to  out  1  divider timed out
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  DW  operand to divider, held stable from ISSUE through WAIT
- div_divisor  out  DW  operand to divider, held stable from ISSUE through WAIT
- div_quotient  in  QW  divider result, valid when div_done=1
- div_done  in  1  divider completion pulse
- busy  out  1  state != IDLE
- stray_done  out  1  sticky: div_done seen outside WAIT

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, rr pointer=0.
  - All outputs 0, including operand, response and stray_done registers.
  - Applies mid-operation too: any in-flight divide is abandoned and no response is issued. The divider is reset by its own port.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits 0. req_ready is 0 in every other state.
  - On grant:
    - Capture operands and id.
    - ptr <= winner+1 mod NREQ.
    - If captured divisor == 0: next state RESP with rsp_quotient={QW{1}}, rsp_dz=1.
    - Otherwise: next state ISSUE.
  - No valid request: remain in IDLE, ptr unchanged.
- ISSUE:
  - div_start=1 for exactly this cycle; timer cleared to 0.
  - Next state WAIT.
- WAIT:
  - Timer increments each cycle.
  - If div_done=1: latch div_quotient, rsp_dz=0, rsp_to=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_quotient=0, rsp_to=1, go to RESP.
  - div_done and timeout in the same cycle: done wins, rsp_to=0.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_quotient/rsp_dz/rsp_to held stable until rsp_valid&rsp_ready.
  - On that handshake cycle go to IDLE; rsp_valid=0 the next cycle.
  - A new grant is possible at the earliest one cycle after the handshake (IDLE cycle).
- Latency:
  - Grant at cycle G, div_start at G+1, div_done at D ⇒ rsp_valid from D+1.
  - Zero divisor ⇒ rsp_valid from G+1.
- stray_done: set when div_done=1 in IDLE, ISSUE or RESP; cleared only by reset. A stray done never alters response data.
- Operand widths are passed unmodified; no sign handling. The quotient is produced by the divider.
- req_* inputs are sampled only in the grant cycle; later changes by a requester are ignored.

Test Plan:
- Single request: req_valid=0001, dividend=13'd100, divisor=13'd400, divider model returns 12'h400 after 14 cycles → req_ready=0001 at G, div_start at G+1, rsp_valid at done+1, rsp_id=0, rsp_quotient=12'h400, dz=0, to=0.
- Round-robin fairness: req_valid=1111 held, rsp_ready=1 → grants in order 0,1,2,3,0; no requester granted twice before all others.
- Divide by zero: requester 2, divisor=0 → div_start never asserted, rsp_valid at G+1, rsp_id=2, rsp_quotient=12'hFFF, rsp_dz=1.
- Timeout and collision: divider model never asserts done → rsp_valid with rsp_to=1, quotient 0, after TIMEOUT cycles in WAIT. Then done asserted exactly at timer=TIMEOUT-1 → normal response, to=0.
- Backpressure and stray done: rsp_ready=0 for 10 cycles in RESP → outputs stable, no new req_ready. div_done pulsed during RESP → stray_done=1, rsp_quotient unchanged.
- Reset mid-WAIT: rst=0 for one cycle → next cycle all outputs 0, state IDLE, ptr=0. Late div_done in IDLE sets stray_done and produces no response.
